operador_param: RTL and testbench
=================================

OPERADOR_PARAM -- requirements
Module: operador_param

Interface
REQ-001 SHALL have parameter W, default 4: operand width in bits, legal range 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port clr, input, 1: synchronous clear; zeroes result and aborts any operation.
REQ-005 SHALL have port start, input, 1: request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port OP, input, 4: opcode; 4'b1010 MUL, 4'b1011 SUB, 4'b1100 ADD, 4'b1101 DIV.
REQ-007 SHALL have ports A and B, input, W each: unsigned operands, captured when start is accepted.
REQ-008 SHALL have port result, output, 2W: registered operation result.
REQ-009 SHALL have port sinal, output, 1: equals result[2W-1].
REQ-010 SHALL have port busy, output, 1: high while state is not IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when result or err is updated.
REQ-012 SHALL have port err, output, 1: registered; set on invalid opcode or divide-by-zero.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE and capture A, B and OP in that cycle; start outside IDLE is ignored.
REQ-015 ADD: after acceptance, go to DONE; result = zero-extended A+B in 2W bits.
REQ-016 SUB: after acceptance, go to DONE; result = (A-B) mod 2^(2W), two's complement, so a negative difference sets sinal.
REQ-017 MUL: go to RUN for exactly W cycles of shift-add (one multiplier bit per cycle), then DONE; result = A*B.
REQ-018 DIV: go to RUN for exactly W cycles of restoring division, then DONE; result = {remainder[W-1:0], quotient[W-1:0]}.
REQ-019 DIV with B=0: go straight to DONE with err=1; result is unchanged.
REQ-020 Invalid opcode: go straight to DONE with err=1; result is unchanged.
REQ-021 A valid operation SHALL clear err when it completes.
REQ-022 Latency from the accepting edge to done high SHALL be 1 cycle for ADD, SUB and error cases, and W+1 cycles for MUL and DIV.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; a new start can be accepted the cycle after DONE.
REQ-024 result and err SHALL hold their values between operations.
REQ-025 Intermediate RUN values SHALL never appear on result.
REQ-026 clr SHALL, in any state, force next-cycle state IDLE, result=0, err=0 and done=0.
REQ-027 If clr and start are high together, clr SHALL win and start is ignored.
REQ-028 Operand or OP changes after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL set state=IDLE, result=0, sinal=0, busy=0, done=0, err=0, and clear internal registers.
REQ-030 reset SHALL take priority over clr and start.
REQ-031 reset during RUN SHALL abort the operation with no done pulse.

Structure
REQ-032 A shared package operador_pkg SHALL hold the opcode constants (OP_MUL, OP_SUB, OP_ADD, OP_DIV) and the FSM state typedef.
REQ-033 The multicycle datapath SHALL be a sub-module operador_seq_core(W), containing the shift-add multiplier, the restoring divider and the bit counter.
REQ-034 The top level SHALL contain the FSM, the ADD/SUB logic and the output registers.

Verification (W=4)
REQ-035 MUL: A=15, B=15, start pulse -> busy for 5 cycles, done at cycle 5, result=8'hE1, sinal=1.
REQ-036 SUB: A=3, B=5 -> done at cycle 1, result=8'hFE, sinal=1, err=0.
REQ-037 DIV: A=13, B=4 -> done at cycle 5, result=8'h13; then DIV with A=9, B=0 -> done at cycle 1, err=1, result stays 8'h13.
REQ-038 ADD: A=9, B=9 -> result=8'h12; OP=4'b0111 -> err=1 with result unchanged.
REQ-039 Reset mid-operation: start MUL, raise reset at cycle 2 -> all outputs 0 next cycle, no done pulse; start asserted while busy is ignored.
REQ-040 Clear mid-operation: assert clr during RUN -> IDLE with result=0; clr and start together -> start ignored.

Source files
------------

// File: rtl/operador_pkg.sv
// rtl/operador_pkg.sv - opcode constants and FSM state encoding shared by operador_param
package operador_pkg;

    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_SUB = 4'b1011;
    localparam logic [3:0] OP_ADD = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/operador_seq_core.sv
// rtl/operador_seq_core.sv - W-cycle shift-add multiplier and restoring divider with bit counter
module operador_seq_core #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           load,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           last,
    output logic [2*W-1:0] res_next
);

    localparam int CW = $clog2(W);

    logic [CW-1:0]  cnt;
    logic           run;
    logic           div_mode;

    logic [2*W-1:0] mul_acc;
    logic [2*W-1:0] mul_mcand;
    logic [W-1:0]   mul_mplier;

    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic [W-1:0]   dvsr;

    logic [2*W-1:0] mul_acc_n;
    logic [W:0]     shifted;
    logic           fits;
    logic [W:0]     trial;
    logic [W-1:0]   rem_n;
    logic [W-1:0]   quo_n;

    // One multiplier bit per step, LSB first; partial product accumulates in mul_acc.
    assign mul_acc_n = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    // Restoring step: bring in next dividend bit, subtract divisor only when it fits.
    // The kept remainder is always below the divisor, so it fits back in W bits.
    assign shifted = {rem, quo[W-1]};
    assign fits    = (shifted >= {1'b0, dvsr});
    assign trial   = shifted - {1'b0, dvsr};
    assign rem_n   = fits ? trial[W-1:0] : shifted[W-1:0];
    assign quo_n   = {quo[W-2:0], fits};

    // The top captures res_next on the edge that performs the final step.
    assign res_next = div_mode ? {rem_n, quo_n} : mul_acc_n;
    assign last     = run && (cnt == CW'(W - 1));

    // Operand load, then one step per cycle for exactly W cycles.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt        <= '0;
            run        <= 1'b0;
            div_mode   <= 1'b0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
        end else if (load) begin
            cnt        <= '0;
            run        <= 1'b1;
            div_mode   <= is_div;
            mul_acc    <= '0;
            mul_mcand  <= {{W{1'b0}}, a};
            mul_mplier <= b;
            rem        <= '0;
            quo        <= a;
            dvsr       <= b;
        end else if (run) begin
            cnt        <= cnt + CW'(1);
            run        <= !last;
            mul_acc    <= mul_acc_n;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            rem        <= rem_n;
            quo        <= quo_n;
        end
    end

endmodule

// File: rtl/operador_param.sv
// rtl/operador_param.sv - parameterised ADD/SUB/MUL/DIV operator with IDLE/RUN/DONE control
import operador_pkg::*;

module operador_param #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           start,
    input  logic [3:0]     OP,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] result,
    output logic           sinal,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_t         state;

    logic           accept;
    logic           seq_ok;
    logic           core_load;
    logic           core_last;
    logic [2*W-1:0] core_res;
    logic [2*W-1:0] add_res;
    logic [2*W-1:0] sub_res;

    assign accept = (state == ST_IDLE) && start;

    // Division by zero never enters RUN; it finishes immediately as an error.
    assign seq_ok    = (OP == OP_MUL) || ((OP == OP_DIV) && (B != '0));
    assign core_load = accept && seq_ok && !clr;

    assign add_res = {{W{1'b0}}, A} + {{W{1'b0}}, B};
    assign sub_res = {{W{1'b0}}, A} - {{W{1'b0}}, B};

    assign sinal = result[2*W-1];
    assign busy  = (state != ST_IDLE);

    operador_seq_core #(.W(W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (core_load),
        .is_div   (OP == OP_DIV),
        .a        (A),
        .b        (B),
        .last     (core_last),
        .res_next (core_res)
    );

    // Control FSM and output registers; result only ever takes final values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            result <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else if (clr) begin
            state  <= ST_IDLE;
            result <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (OP == OP_ADD) begin
                            result <= add_res;
                            err    <= 1'b0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else if (OP == OP_SUB) begin
                            result <= sub_res;
                            err    <= 1'b0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else if (seq_ok) begin
                            state  <= ST_RUN;
                        end else begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (core_last) begin
                        result <= core_res;
                        err    <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operador_param.sv
// tb/tb_operador_param.sv - self-checking bench for operador_param (W=4)
module tb_operador_param;

    localparam int W = 4;
    typedef logic [2*W-1:0] res_t;

    localparam logic [3:0] C_MUL = 4'b1010;
    localparam logic [3:0] C_SUB = 4'b1011;
    localparam logic [3:0] C_ADD = 4'b1100;
    localparam logic [3:0] C_DIV = 4'b1101;
    localparam logic [3:0] C_BAD = 4'b0111;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         clr   = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   OP    = '0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    res_t         result;
    logic         sinal;
    logic         busy;
    logic         done;
    logic         err;

    int tests = 0;
    int fails = 0;

    operador_param #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .start  (start),
        .OP     (OP),
        .A      (A),
        .B      (B),
        .result (result),
        .sinal  (sinal),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted op occupies the block for L cycles,
    // its outcome appears (with done) in the last of them.
    int   m_left = 0;
    res_t m_result = '0;
    logic m_err = 1'b0;
    logic m_live = 1'b0;
    res_t p_res = '0;
    logic p_err = 1'b0;
    logic p_upd = 1'b0;

    always @(posedge clk) begin : model
        int   left_n;
        int   ia;
        int   ib;
        res_t res_n;
        res_t pres_n;
        logic err_n;
        logic perr_n;
        logic pupd_n;
        left_n = m_left;
        res_n  = m_result;
        err_n  = m_err;
        pres_n = p_res;
        perr_n = p_err;
        pupd_n = p_upd;
        ia     = int'(A);
        ib     = int'(B);
        if (reset || clr) begin
            left_n = 0;
            res_n  = '0;
            err_n  = 1'b0;
        end else begin
            if (m_left > 0) begin
                left_n = m_left - 1;
            end else if (start) begin
                left_n = 1;
                pupd_n = 1'b1;
                perr_n = 1'b0;
                case (OP)
                    C_ADD: pres_n = res_t'(ia + ib);
                    C_SUB: pres_n = res_t'(ia - ib);
                    C_MUL: begin
                        pres_n = res_t'(ia * ib);
                        left_n = W + 1;
                    end
                    C_DIV: begin
                        if (ib == 0) begin
                            pupd_n = 1'b0;
                            perr_n = 1'b1;
                        end else begin
                            pres_n = res_t'((ia % ib) * (1 << W) + ia / ib);
                            left_n = W + 1;
                        end
                    end
                    default: begin
                        pupd_n = 1'b0;
                        perr_n = 1'b1;
                    end
                endcase
            end
            if (left_n == 1) begin
                if (pupd_n) res_n = pres_n;
                err_n = perr_n;
            end
        end
        m_left   <= left_n;
        m_result <= res_n;
        m_err    <= err_n;
        p_res    <= pres_n;
        p_err    <= perr_n;
        p_upd    <= pupd_n;
        m_live   <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_result", result, m_result);
            chk("cyc_sinal", sinal, m_result[2*W-1]);
            chk("cyc_busy", busy, (m_left != 0));
            chk("cyc_done", done, (m_left == 1));
            chk("cyc_err", err, m_err);
        end
    end

    // Start one op from the next idle cycle; returns cycles until done (bounded).
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        @(negedge clk);
        OP = op;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        OP = ~op;
        A = ~a;
        B = ~b;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("op_done_seen", done, 1'b1);
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_sinal", sinal, 1'b0);
        reset = 1'b0;

        run_op(C_MUL, 4'd15, 4'd15, lat);
        chk("mul_lat", lat, 5);
        chk("mul_res", result, 8'hE1);
        chk("mul_sinal", sinal, 1'b1);

        run_op(C_SUB, 4'd3, 4'd5, lat);
        chk("sub_lat", lat, 1);
        chk("sub_res", result, 8'hFE);
        chk("sub_sinal", sinal, 1'b1);
        chk("sub_err", err, 1'b0);

        run_op(C_DIV, 4'd13, 4'd4, lat);
        chk("div_lat", lat, 5);
        chk("div_res", result, 8'h13);

        run_op(C_DIV, 4'd9, 4'd0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_err", err, 1'b1);
        chk("div0_res", result, 8'h13);

        run_op(C_ADD, 4'd9, 4'd9, lat);
        chk("add_res", result, 8'h12);
        chk("add_err_clr", err, 1'b0);

        run_op(C_BAD, 4'd1, 4'd1, lat);
        chk("bad_lat", lat, 1);
        chk("bad_err", err, 1'b1);
        chk("bad_res", result, 8'h12);

        run_op(C_MUL, 4'd7, 4'd6, lat);
        chk("mul2_res", result, 8'h2A);
        run_op(C_DIV, 4'd15, 4'd1, lat);
        chk("div2_res", result, 8'h0F);
        run_op(C_DIV, 4'd2, 4'd15, lat);
        chk("div3_res", result, 8'h20);
        run_op(C_SUB, 4'd0, 4'd15, lat);
        chk("sub2_res", result, 8'hF1);
        run_op(C_ADD, 4'd15, 4'd15, lat);
        chk("add2_res", result, 8'h1E);
        chk("add2_sinal", sinal, 1'b0);

        // Start raised while busy must not disturb the running MUL.
        @(negedge clk);
        OP = C_MUL; A = 4'd3; B = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; OP = C_ADD; A = 4'd1; B = 4'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_start_done", done, 1'b1);
        chk("busy_start_res", result, 8'h0F);

        // Reset in the middle of RUN.
        @(negedge clk);
        OP = C_MUL; A = 4'd15; B = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_result", result, 8'h00);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", done, 1'b0);
        end

        // Clear in the middle of RUN after an error was flagged.
        run_op(C_ADD, 4'd5, 4'd6, lat);
        chk("pre_clr_res", result, 8'h0B);
        run_op(C_BAD, 4'd0, 4'd0, lat);
        @(negedge clk);
        OP = C_MUL; A = 4'd9; B = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_result", result, 8'h00);
        chk("clr_err", err, 1'b0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_done", done, 1'b0);

        // clr wins over a simultaneous start.
        run_op(C_ADD, 4'd2, 4'd3, lat);
        chk("pre_clr2_res", result, 8'h05);
        @(negedge clk);
        clr = 1'b1; start = 1'b1; OP = C_ADD; A = 4'd7; B = 4'd7;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        chk("clr_start_busy", busy, 1'b0);
        chk("clr_start_res", result, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_start_no_done", done, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
